// File: rtl/decoder_5x32_reg.sv
// Registered 5-to-32 one-hot decoder built from nested 2x4 / 3x8 / 4x16 enable-gated stages.
// D is updated one cycle after I is sampled; synchronous active-high reset clears every select line.

module dec_2x4 (
  input  logic       en,
  input  logic [1:0] sel,
  output logic [3:0] y
);
  always_comb begin
    y = 4'b0000;
    if (en) begin
      case (sel)
        2'd0:    y = 4'b0001;
        2'd1:    y = 4'b0010;
        2'd2:    y = 4'b0100;
        default: y = 4'b1000;
      endcase
    end
  end
endmodule

module dec_3x8 (
  input  logic       en,
  input  logic [2:0] sel,
  output logic [7:0] y
);
  logic [3:0] lo;
  logic [3:0] hi;

  dec_2x4 u_lo (.en(en & ~sel[2]), .sel(sel[1:0]), .y(lo));
  dec_2x4 u_hi (.en(en &  sel[2]), .sel(sel[1:0]), .y(hi));

  assign y = {hi, lo};
endmodule

module dec_4x16 (
  input  logic        en,
  input  logic [3:0]  sel,
  output logic [15:0] y
);
  logic [7:0] lo;
  logic [7:0] hi;

  dec_3x8 u_lo (.en(en & ~sel[3]), .sel(sel[2:0]), .y(lo));
  dec_3x8 u_hi (.en(en &  sel[3]), .sel(sel[2:0]), .y(hi));

  assign y = {hi, lo};
endmodule

module decoder_5x32_reg (
  input  logic        C,
  input  logic        R,
  input  logic [4:0]  I,
  output logic [31:0] D
);
  logic [15:0] lo;
  logic [15:0] hi;
  logic [31:0] dec;

  // MSB picks which half is enabled; the other half decodes to all zeros.
  dec_4x16 u_lo (.en(~I[4]), .sel(I[3:0]), .y(lo));
  dec_4x16 u_hi (.en( I[4]), .sel(I[3:0]), .y(hi));

  assign dec = {hi, lo};

  always_ff @(posedge C) begin
    if (R) D <= 32'h0000_0000;
    else   D <= dec;
  end
endmodule

// File: tb/tb_decoder_5x32_reg.sv
// Scoreboard bench for decoder_5x32_reg: expected words are queued as stimulus is driven
// and popped for comparison once the clock edge has registered the result.

module tb_decoder_5x32_reg;
  logic        C = 1'b0;
  logic        R = 1'b1;
  logic [4:0]  I = 5'd0;
  logic [31:0] D;

  int passed = 0;
  int total  = 0;
  logic [31:0] sb[$];

  decoder_5x32_reg dut (.C(C), .R(R), .I(I), .D(D));

  always #5 C = ~C;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, passed=%0d total=%0d", passed, total);
    $fatal(1);
  end

  // Drive away from the active edge, queue the expectation, then settle just past the edge.
  task automatic step(input logic [4:0] idx, input logic rst, input logic [31:0] exp);
    @(negedge C);
    I = idx;
    R = rst;
    sb.push_back(exp);
    @(posedge C);
    #1;
  endtask

  task automatic test_reset;
    logic [31:0] e;
    step(5'd7, 1'b1, 32'h0000_0000);
    e = sb.pop_front();
    total++;
    if (D !== e) $display("FAIL reset_clear: got %h want %h", D, e);
    else passed++;
    step(5'd7, 1'b0, 32'h0000_0080);
    e = sb.pop_front();
    total++;
    if (D !== e) $display("FAIL reset_release: got %h want %h", D, e);
    else passed++;
  endtask

  task automatic test_lower;
    logic [4:0]  idx [5] = '{5'd1, 5'd5, 5'd4, 5'd12, 5'd13};
    logic [31:0] exp [5] = '{32'h0000_0002, 32'h0000_0020, 32'h0000_0010,
                             32'h0000_1000, 32'h0000_2000};
    logic [31:0] e;
    for (int k = 0; k < 5; k++) begin
      step(idx[k], 1'b0, exp[k]);
      e = sb.pop_front();
      total++;
      if (D !== e) $display("FAIL lower_i%0d: got %h want %h", idx[k], D, e);
      else passed++;
    end
  endtask

  task automatic test_upper;
    logic [4:0]  idx [4] = '{5'd16, 5'd20, 5'd19, 5'd31};
    logic [31:0] exp [4] = '{32'h0001_0000, 32'h0010_0000, 32'h0008_0000, 32'h8000_0000};
    logic [31:0] e;
    for (int k = 0; k < 4; k++) begin
      step(idx[k], 1'b0, exp[k]);
      e = sb.pop_front();
      total++;
      if (D !== e) $display("FAIL upper_i%0d: got %h want %h", idx[k], D, e);
      else passed++;
    end
  endtask

  task automatic test_sweep;
    logic [31:0] e;
    for (int k = 0; k < 32; k++) begin
      step(k[4:0], 1'b0, 32'h1 << k);
      e = sb.pop_front();
      total++;
      if (D !== e) $display("FAIL sweep_i%0d: got %h want %h", k, D, e);
      else passed++;
      total++;
      if ($countones(D) !== 1) $display("FAIL sweep_onehot_i%0d: got popcount %0d want 1", k, $countones(D));
      else passed++;
    end
  endtask

  task automatic test_latency;
    logic [31:0] e;
    step(5'd3, 1'b0, 32'h0000_0008);
    e = sb.pop_front();
    total++;
    if (D !== e) $display("FAIL latency_first: got %h want %h", D, e);
    else passed++;
    // Change the index mid-cycle; the register must not follow it yet.
    @(negedge C);
    I = 5'd9;
    #1;
    total++;
    if (D !== 32'h0000_0008) $display("FAIL latency_hold_midcycle: got %h want %h", D, 32'h0000_0008);
    else passed++;
    sb.push_back(32'h0000_0200);
    @(posedge C);
    #1;
    e = sb.pop_front();
    total++;
    if (D !== e) $display("FAIL latency_update: got %h want %h", D, e);
    else passed++;
    for (int k = 0; k < 2; k++) begin
      step(5'd9, 1'b0, 32'h0000_0200);
      e = sb.pop_front();
      total++;
      if (D !== e) $display("FAIL hold_constant_%0d: got %h want %h", k, D, e);
      else passed++;
    end
    // A reset pulse that never sees a rising edge must leave D untouched.
    R = 1'b1;
    #2;
    R = 1'b0;
    #1;
    total++;
    if (D !== 32'h0000_0200) $display("FAIL reset_between_edges: got %h want %h", D, 32'h0000_0200);
    else passed++;
  endtask

  task automatic test_reset_mid;
    logic [4:0]  idx [4] = '{5'd21, 5'd22, 5'd22, 5'd22};
    logic        rst [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic [31:0] exp [4] = '{32'h0020_0000, 32'h0040_0000, 32'h0000_0000, 32'h0040_0000};
    logic [31:0] e;
    for (int k = 0; k < 4; k++) begin
      step(idx[k], rst[k], exp[k]);
      e = sb.pop_front();
      total++;
      if (D !== e) $display("FAIL reset_mid_step%0d: got %h want %h", k, D, e);
      else passed++;
    end
  endtask

  task automatic test_back_to_back;
    logic [4:0]  idx [6] = '{5'd7, 5'd8, 5'd15, 5'd16, 5'd23, 5'd24};
    logic [31:0] e;
    logic [31:0] prev;
    prev = 32'h0;
    for (int k = 0; k < 6; k++) begin
      step(idx[k], 1'b0, 32'h1 << idx[k]);
      e = sb.pop_front();
      total++;
      if (D !== e) $display("FAIL boundary_i%0d: got %h want %h", idx[k], D, e);
      else passed++;
      if (k % 2 == 1) begin
        total++;
        if ((D & prev) !== 32'h0) $display("FAIL boundary_overlap_i%0d: got %h want %h", idx[k], D & prev, 32'h0);
        else passed++;
      end
      prev = D;
    end
  endtask

  initial begin
    test_reset;
    test_lower;
    test_upper;
    test_sweep;
    test_latency;
    test_reset_mid;
    test_back_to_back;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
